// File: rtl/mem_stage_sram_ctrl_pkg.sv
// Shared definitions for the MEM-stage SRAM controller: FSM encoding,
// operation flag, default geometry and the memory bus widths.
package mem_stage_sram_ctrl_pkg;

  localparam int unsigned DATA_BASE_DEF     = 1024;
  localparam int unsigned ACCESS_CYCLES_DEF = 2;
  localparam int unsigned SRAM_AW_DEF       = 18;
  localparam int unsigned SRAM_DW           = 16;
  localparam int unsigned WORD_W            = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LO   = 2'd1,
    ST_HI   = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } op_t;

endpackage

// File: rtl/mem_stage_sram_ctrl_if.sv
// Pipeline-side bus between the EXE/MEM register and the MEM-stage controller.
//
// Handshake: the pipeline presents a request (mem_r_en or mem_w_en) together
// with alu_result/st_val. The controller answers with stall, which stays high
// until the access is complete; the request is consumed on the first clock
// edge where stall is low. mem_read_data is valid from that edge on for a load
// and holds until the next load completes.
interface mem_stage_sram_ctrl_if;
  import mem_stage_sram_ctrl_pkg::*;

  logic              mem_r_en;
  logic              mem_w_en;
  logic [WORD_W-1:0] alu_result;
  logic [WORD_W-1:0] st_val;
  logic              stall;
  logic [WORD_W-1:0] mem_read_data;

  modport master (
    output mem_r_en, mem_w_en, alu_result, st_val,
    input  stall, mem_read_data
  );

  modport slave (
    input  mem_r_en, mem_w_en, alu_result, st_val,
    output stall, mem_read_data
  );
endinterface

// File: rtl/mem_access_timer.sv
// Phase counter: counts 0..ACCESS_CYCLES-1 while enabled, wraps to 0 on the
// terminal count, and is forced to 0 by clr_i.
module mem_access_timer #(
  parameter int unsigned ACCESS_CYCLES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);
  localparam int unsigned CW = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(ACCESS_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tc_o = (cnt_q == LAST);

  // Next count: clear wins, otherwise step and wrap at the terminal count.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = tc_o ? '0 : cnt_q + CW'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
endmodule

// File: rtl/mem_stage_sram_ctrl.sv
// MEM-stage controller: splits one 32-bit load/store into a low and a high
// 16-bit phase on an asynchronous SRAM, stalling the pipeline meanwhile.
module mem_stage_sram_ctrl
  import mem_stage_sram_ctrl_pkg::*;
#(
  parameter int unsigned DATA_BASE     = DATA_BASE_DEF,
  parameter int unsigned ACCESS_CYCLES = ACCESS_CYCLES_DEF,
  parameter int unsigned SRAM_AW       = SRAM_AW_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  mem_stage_sram_ctrl_if.slave pipe,
  inout  wire  [SRAM_DW-1:0]   sram_dq,
  output logic [SRAM_AW-1:0]   sram_addr,
  output logic                 sram_we_n,
  output logic                 sram_oe_n,
  output logic                 sram_ce_n,
  output logic                 sram_ub_n,
  output logic                 sram_lb_n,
  output state_t               state_o
);

  state_t             state_q, state_d;
  op_t                op_q, op_d;
  logic [SRAM_AW-2:0] word_q, word_d;
  logic [WORD_W-1:0]  st_q, st_d;
  logic [SRAM_DW-1:0] rd_lo_q, rd_lo_d;
  logic [WORD_W-1:0]  rdata_q, rdata_d;

  logic               req;
  logic               active;
  logic               tc;
  logic               dq_oe;
  logic [SRAM_DW-1:0] dq_out;

  assign req     = pipe.mem_r_en | pipe.mem_w_en;
  assign active  = (state_q == ST_LO) || (state_q == ST_HI);
  assign state_o = state_q;

  // Stall covers the request cycle through the last HI cycle; DONE releases.
  assign pipe.stall         = req & (state_q != ST_DONE) & ~rst;
  assign pipe.mem_read_data = rdata_q;

  mem_access_timer #(.ACCESS_CYCLES(ACCESS_CYCLES)) u_timer (
    .clk   (clk),
    .rst   (rst),
    .clr_i (~active),
    .en_i  (active),
    .tc_o  (tc)
  );

  // Next-state logic: latch the request in IDLE, walk LO -> HI -> DONE.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    word_d  = word_q;
    st_d    = st_q;
    rd_lo_d = rd_lo_q;
    rdata_d = rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          // Address wraps modulo the SRAM word space; write wins over read.
          word_d  = (SRAM_AW-1)'((pipe.alu_result - WORD_W'(DATA_BASE)) >> 2);
          st_d    = pipe.st_val;
          op_d    = pipe.mem_w_en ? OP_WR : OP_RD;
          state_d = ST_LO;
        end
      end
      ST_LO: begin
        if (tc) begin
          if (op_q == OP_RD) rd_lo_d = sram_dq;
          state_d = ST_HI;
        end
      end
      ST_HI: begin
        if (tc) begin
          if (op_q == OP_RD) rdata_d = {sram_dq, rd_lo_q};
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State and latch registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      op_q    <= OP_RD;
      word_q  <= '0;
      st_q    <= '0;
      rd_lo_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      word_q  <= word_d;
      st_q    <= st_d;
      rd_lo_q <= rd_lo_d;
      rdata_q <= rdata_d;
    end
  end

  // SRAM bus decode from the registered state only, so reset idles it cleanly.
  always_comb begin
    sram_ce_n = ~active;
    sram_oe_n = ~(active & (op_q == OP_RD));
    sram_we_n = ~(active & (op_q == OP_WR));
    sram_addr = '0;
    dq_out    = st_q[SRAM_DW-1:0];
    dq_oe     = active & (op_q == OP_WR);
    if (state_q == ST_LO) begin
      sram_addr = {word_q, 1'b0};
    end else if (state_q == ST_HI) begin
      sram_addr = {word_q, 1'b1};
      dq_out    = st_q[WORD_W-1:SRAM_DW];
    end
  end

  assign sram_dq   = dq_oe ? dq_out : {SRAM_DW{1'bz}};
  assign sram_ub_n = 1'b0;
  assign sram_lb_n = 1'b0;

endmodule

// File: tb/tb_mem_stage_sram_ctrl.sv
// Bench for mem_stage_sram_ctrl: a default build driven from a transaction
// table with a bus scoreboard, plus an ACCESS_CYCLES=1 build for the
// read+write collision case.
module tb_mem_stage_sram_ctrl;
  import mem_stage_sram_ctrl_pkg::*;

  localparam int AC = 2;
  localparam int AW = 18;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT, default build ----------------
  mem_stage_sram_ctrl_if pipe ();
  wire  [15:0]   sram_dq;
  logic [AW-1:0] sram_addr;
  logic          we_n, oe_n, ce_n, ub_n, lb_n;
  state_t        st;

  mem_stage_sram_ctrl #(.DATA_BASE(1024), .ACCESS_CYCLES(AC), .SRAM_AW(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .pipe      (pipe.slave),
    .sram_dq   (sram_dq),
    .sram_addr (sram_addr),
    .sram_we_n (we_n),
    .sram_oe_n (oe_n),
    .sram_ce_n (ce_n),
    .sram_ub_n (ub_n),
    .sram_lb_n (lb_n),
    .state_o   (st)
  );

  // Asynchronous SRAM model
  logic [15:0] sram_mem [0:(1<<AW)-1];
  assign sram_dq = (!ce_n && !oe_n && we_n) ? sram_mem[sram_addr] : 16'bz;
  always @(posedge clk) if (!ce_n && !we_n) sram_mem[sram_addr] <= sram_dq;

  // ---------------- DUT, single-cycle phases ----------------
  mem_stage_sram_ctrl_if pipe1 ();
  wire  [15:0]   sram_dq1;
  logic [AW-1:0] sram_addr1;
  logic          we1_n, oe1_n, ce1_n, ub1_n, lb1_n;
  state_t        st1;

  mem_stage_sram_ctrl #(.DATA_BASE(1024), .ACCESS_CYCLES(1), .SRAM_AW(AW)) dut1 (
    .clk       (clk),
    .rst       (rst),
    .pipe      (pipe1.slave),
    .sram_dq   (sram_dq1),
    .sram_addr (sram_addr1),
    .sram_we_n (we1_n),
    .sram_oe_n (oe1_n),
    .sram_ce_n (ce1_n),
    .sram_ub_n (ub1_n),
    .sram_lb_n (lb1_n),
    .state_o   (st1)
  );

  logic [15:0] sram1_mem [0:15];
  always @(posedge clk) if (!ce1_n && !we1_n) sram1_mem[sram_addr1[3:0]] <= sram_dq1;

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  logic [35:0] exp_q[$];            // {addr, dq, we_n, oe_n} per SRAM bus cycle
  logic [15:0] sb_mem [0:(1<<AW)-1]; // expected SRAM content

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] exp_rdata;
  } vec_t;

  // Drive one access from an IDLE-cycle negedge; returns at the negedge after DONE.
  task automatic do_vec(input vec_t v, input string tag);
    logic [AW-2:0] w;
    logic [AW-1:0] a;
    logic [15:0]   d;
    int            n_stall;
    int            c0;
    bit            done;
    c0 = cyc;
    pipe.mem_r_en   = v.rd;
    pipe.mem_w_en   = v.wr;
    pipe.alu_result = v.addr;
    pipe.st_val     = v.data;
    w = (AW-1)'((v.addr - 32'd1024) >> 2);
    for (int ph = 0; ph < 2; ph++) begin
      a = {w, ph[0]};
      d = (ph == 1) ? v.data[31:16] : v.data[15:0];
      if (v.wr) sb_mem[a] = d;
      for (int c = 0; c < AC; c++) begin
        if (v.wr) exp_q.push_back({a, d, 1'b0, 1'b1});
        else      exp_q.push_back({a, sb_mem[a], 1'b1, 1'b0});
      end
    end
    n_stall = 0;
    done    = 1'b0;
    for (int k = 0; k < 20 && !done; k++) begin
      #1;
      if (pipe.stall) n_stall++;
      if (!ce_n) begin
        if (exp_q.size() == 0) check({tag, " extra_bus_cycle"}, 64'(sram_addr), 64'hFFFF_FFFF);
        else check({tag, " bus"}, 64'({sram_addr, sram_dq, we_n, oe_n}), 64'(exp_q.pop_front()));
      end
      if (!pipe.stall) begin
        done = 1'b1;
      end else begin
        @(negedge clk);
        // Inputs wander during the stall; the latched request must be used.
        pipe.alu_result = $urandom;
        pipe.st_val     = $urandom;
      end
    end
    check({tag, " timeout"}, 64'(done), 64'd1);
    check({tag, " stall_cycles"}, 64'(n_stall), 64'(1 + 2*AC));
    check({tag, " done_state"}, 64'(st), 64'(ST_DONE));
    check({tag, " bus_left"}, 64'(exp_q.size()), 64'd0);
    check({tag, " rdata"}, 64'(pipe.mem_read_data), 64'(v.exp_rdata));
    exp_q.delete();
    @(negedge clk);
    pipe.mem_r_en = 1'b0;
    pipe.mem_w_en = 1'b0;
    check({tag, " cycles"}, 64'(cyc - c0), 64'(2 + 2*AC));
  endtask

  vec_t vecs [9];

  initial begin
    int c0;
    int n_stall;
    int wr_seen;
    int oe_low;
    logic [31:0] r1, r2, a7;
    r1 = $urandom;
    r2 = $urandom;
    a7 = 32'd1024 + 4 * $urandom_range(8, 4000);
    vecs[0] = '{1'b0, 1'b1, 32'd1028, 32'hDEADBEEF, 32'h0};
    vecs[1] = '{1'b1, 1'b0, 32'd1028, 32'h0,        32'hDEADBEEF};
    vecs[2] = '{1'b1, 1'b0, 32'd1028, 32'h0,        32'hDEADBEEF};
    vecs[3] = '{1'b0, 1'b1, 32'd1032, 32'h12345678, 32'hDEADBEEF};
    vecs[4] = '{1'b1, 1'b0, 32'd1032, 32'h0,        32'h12345678};
    vecs[5] = '{1'b0, 1'b1, 32'd1020, r1,           32'h12345678};
    vecs[6] = '{1'b1, 1'b0, 32'd1020, 32'h0,        r1};
    vecs[7] = '{1'b0, 1'b1, a7,       r2,           r1};
    vecs[8] = '{1'b1, 1'b0, a7,       32'h0,        r2};

    pipe.mem_r_en = 1'b0;  pipe.mem_w_en = 1'b0;
    pipe.alu_result = '0;  pipe.st_val = '0;
    pipe1.mem_r_en = 1'b0; pipe1.mem_w_en = 1'b0;
    pipe1.alu_result = '0; pipe1.st_val = '0;

    // Reset with no request
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #1;
    check("rst stall", 64'(pipe.stall), 64'd0);
    check("rst rdata", 64'(pipe.mem_read_data), 64'd0);
    check("rst ctrl", 64'({ce_n, we_n, oe_n}), 64'h7);
    check("rst addr", 64'(sram_addr), 64'd0);
    check("rst state", 64'(st), 64'(ST_IDLE));
    check("rst byte_en", 64'({ub_n, lb_n}), 64'd0);
    @(negedge clk);

    // Table of back-to-back transactions
    for (int i = 0; i < 9; i++) begin
      if (i == 2) c0 = cyc;
      do_vec(vecs[i], $sformatf("vec%0d", i));
      if (i == 3) check("b2b total_cycles", 64'(cyc - c0), 64'd12);
    end
    check("sram lo word1", 64'(sram_mem[2]), 64'hBEEF);
    check("sram hi word1", 64'(sram_mem[3]), 64'hDEAD);
    #1;
    check("idle hold rdata", 64'(pipe.mem_read_data), 64'(r2));

    // Reset in the HI phase of a store
    pipe.mem_w_en = 1'b1; pipe.alu_result = 32'd1040; pipe.st_val = 32'h55AA33CC;
    repeat (3) @(negedge clk);
    #1;
    check("abort in_hi", 64'(st), 64'(ST_HI));
    rst = 1'b1;
    #1;
    check("abort stall_forced", 64'(pipe.stall), 64'd0);
    @(negedge clk);
    #1;
    check("abort state", 64'(st), 64'(ST_IDLE));
    check("abort ctrl", 64'({ce_n, we_n, oe_n}), 64'h7);
    check("abort rdata", 64'(pipe.mem_read_data), 64'd0);
    check("abort stall", 64'(pipe.stall), 64'd0);
    rst = 1'b0;
    pipe.mem_w_en = 1'b0;
    @(negedge clk);
    do_vec('{1'b1, 1'b0, 32'd1028, 32'h0, 32'hDEADBEEF}, "after_rst");

    // Read and write together, single-cycle phases
    pipe1.mem_r_en = 1'b1; pipe1.mem_w_en = 1'b1;
    pipe1.alu_result = 32'd1024; pipe1.st_val = 32'hA5A55A5A;
    n_stall = 0; wr_seen = 0; oe_low = 0;
    for (int k = 0; k < 10; k++) begin
      #1;
      if (!pipe1.stall) break;
      n_stall++;
      if (!ce1_n && !we1_n) wr_seen++;
      if (!oe1_n) oe_low++;
      @(negedge clk);
    end
    check("both stall_cycles", 64'(n_stall), 64'd3);
    check("both write_cycles", 64'(wr_seen), 64'd2);
    check("both oe_low", 64'(oe_low), 64'd0);
    check("both done_state", 64'(st1), 64'(ST_DONE));
    check("both sram_lo", 64'(sram1_mem[0]), 64'h5A5A);
    check("both sram_hi", 64'(sram1_mem[1]), 64'hA5A5);
    pipe1.mem_r_en = 1'b0; pipe1.mem_w_en = 1'b0;
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
